// File: rtl/icache_fill.sv
// Instruction-cache line-fill engine: fetches a 64-byte line as 16 pipelined 32-bit bus reads,
// assembles it and presents it to the cache for one cycle; drains in-flight reads on abandonment.
//
// state | meaning
// IDLE  | waiting for a miss
// FILL  | issuing reads and collecting words
// DRAIN | miss abandoned, discarding outstanding responses
// DONE  | line_ready pulse, line_data/line_addr valid
module icache_fill #(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         miss_valid,
  input  logic [31:0]  miss_addr,
  output logic         line_ready,
  output logic [511:0] line_data,
  output logic [31:0]  line_addr,
  output logic         bus_req_valid,
  input  logic         bus_req_ready,
  output logic [31:0]  bus_req_addr,
  input  logic         bus_resp_valid,
  input  logic [31:0]  bus_resp_data
);

  typedef enum logic [1:0] {IDLE, FILL, DRAIN, DONE} state_t;

  state_t       state, state_nxt;
  logic [25:0]  base_line;
  logic [31:0]  miss_addr_q;
  logic [4:0]   issue_cnt, recv_cnt, outstanding, recv_nxt;
  logic [479:0] line_buf;
  logic         abort, resp_take, req_fire;

  assign outstanding = issue_cnt - recv_cnt;
  assign abort       = !miss_valid || (miss_addr[31:6] != base_line);
  // Responses with nothing outstanding are stray and must not move the counters.
  assign resp_take   = bus_resp_valid && (recv_cnt != issue_cnt) &&
                       ((state == FILL) || (state == DRAIN));
  assign recv_nxt    = recv_cnt + {4'd0, resp_take};

  assign bus_req_valid = (state == FILL) && !abort && !issue_cnt[4] &&
                         (outstanding < 5'(MAX_OUTSTANDING));
  assign req_fire      = bus_req_valid && bus_req_ready;
  assign bus_req_addr  = {base_line, 6'd0} + {25'd0, issue_cnt, 2'd0};
  assign line_ready    = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (miss_valid) state_nxt = FILL;
      FILL: begin
        if (abort)                                state_nxt = DRAIN;
        else if (resp_take && recv_cnt == 5'd15)  state_nxt = DONE;
      end
      DRAIN: if (recv_nxt == issue_cnt) state_nxt = IDLE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_line   <= '0;
      miss_addr_q <= '0;
      issue_cnt   <= '0;
      recv_cnt    <= '0;
      line_buf    <= '0;
      line_data   <= '0;
      line_addr   <= '0;
    end else if (state == IDLE) begin
      if (miss_valid) begin
        base_line   <= miss_addr[31:6];
        miss_addr_q <= miss_addr;
        issue_cnt   <= '0;
        recv_cnt    <= '0;
      end
    end else begin
      if (req_fire)  issue_cnt <= issue_cnt + 5'd1;
      if (resp_take) recv_cnt  <= recv_nxt;
      if (state == FILL && resp_take) begin
        for (int k = 0; k < 15; k++)
          if (recv_cnt == 5'(k)) line_buf[k*32 +: 32] <= bus_resp_data;
      end
      // The last word goes straight to the output so the previous line stays visible until now.
      if (state == FILL && state_nxt == DONE) begin
        line_data <= {bus_resp_data, line_buf};
        line_addr <= miss_addr_q;
      end
    end
  end

endmodule

// File: doc/icache_fill.md
Name: icache_fill

Overview:
- Line-fill engine directly downstream of the instruction cache's miss port.
- Accepts a miss address from the cache and fetches the 64-byte line (16 x 32-bit words) over a narrow 32-bit pipelined memory bus.
- Assembles the words into a 512-bit line and presents it back to the cache for one cycle.
- Drains and discards in-flight words if the cache abandons the miss.

Parameters:
- MAX_OUTSTANDING, 4, maximum bus reads issued but not yet answered (1..16).

Ports:
- clk  input  1  clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- miss_valid  input  1  cache requests a line fill (cache mem_addr_valid).
- miss_addr  input  32  miss address; bits [31:6] select the line.
- line_ready  output  1  one-cycle pulse: line_data is valid for line_addr.
- line_data  output  512  assembled line; word k in bits [32k+31:32k].
- line_addr  output  32  address the line was fetched for (the captured miss_addr).
- bus_req_valid  output  1  read request valid.
- bus_req_ready  input  1  bus accepts the request this cycle.
- bus_req_addr  output  32  word address, always 4-byte aligned.
- bus_resp_valid  input  1  read data valid; responses return in request order, no backpressure.
- bus_resp_data  input  32  read data.

Behaviour:
- Reset (async, rst_n low), all values immediate:
  - state=IDLE; line_ready=0; bus_req_valid=0; line_data=0; line_addr=0; counters=0.
  - Responses arriving after reset release are ignored until a new fill issues requests; the bus is reset by the same rst_n.
- States: IDLE, FILL, DRAIN, DONE.
- IDLE:
  - If miss_valid=1, capture base = {miss_addr[31:6], 6'b0} and line_addr = miss_addr; clear issue_cnt and recv_cnt; go to FILL.
  - line_ready is never asserted in IDLE.
- FILL:
  - Issue: bus_req_valid=1 while issue_cnt<16 and (issue_cnt - recv_cnt) < MAX_OUTSTANDING.
  - bus_req_addr = base + 4*issue_cnt; issue_cnt increments on bus_req_valid & bus_req_ready.
  - bus_req_valid and bus_req_addr hold stable until accepted.
  - Receive: on bus_resp_valid, word recv_cnt of the line buffer = bus_resp_data; recv_cnt increments.
  - A same-cycle issue and receive updates both counters; the outstanding count is unchanged.
  - When the 16th response is received (recv_cnt 15->16), go to DONE.
  - Abort: if miss_valid=0, or miss_addr[31:6] differs from base[31:6], go to DRAIN; no further requests are issued.
- DRAIN:
  - bus_req_valid=0; consume responses until recv_cnt == issue_cnt; data is discarded.
  - Then go to IDLE.
  - If already drained when entering (e.g. abort on the cycle where issue_cnt == recv_cnt), go to IDLE the next cycle.
- DONE:
  - line_ready=1 for exactly one cycle; line_data = assembled buffer.
  - Next state IDLE.
  - line_data and line_addr hold their values until the next fill completes.
- Latency:
  - With bus_req_ready=1 and a fixed response latency L cycles, line_ready asserts ceil(16/MAX_OUTSTANDING)-paced.
  - Minimum (MAX_OUTSTANDING>=L+1): 1 (capture) + 16 + L + 1 cycles after miss_valid is first seen.
- Widths:
  - issue_cnt and recv_cnt are 5 bits (0..16); the address adder is 32 bits.
  - No wrap is possible inside a line, since base is 64-byte aligned.
- Edge cases:
  - bus_resp_valid while no request is outstanding: ignored; it must not corrupt the counters (assertion in the bench).
  - miss_valid still high in the cycle after DONE: treated as a new miss (the cache normally drops it on hit).
  - Change of miss_addr within the same line during FILL is not an abort.

Test Plan:
- Basic fill:
  - Stimulus: miss_addr=0x0000_1234, bus ready always, latency 2, resp_data = address.
  - Required: requests 0x1200..0x123C in order; line_ready single pulse; line_data[31:0]=0x1200 and [511:480]=0x123C; line_addr=0x1234.
- Outstanding limit:
  - Stimulus: MAX_OUTSTANDING=4, latency 10.
  - Required: never more than 4 unanswered requests; all 16 words correct; bus_req_valid held while throttled.
- Backpressure:
  - Stimulus: bus_req_ready toggles 1,0,0,1...
  - Required: bus_req_addr stable while not ready; no duplicate or skipped addresses.
- Abort mid-fill:
  - Stimulus: miss_valid drops after 6 requests accepted and 3 responses received.
  - Required: enters DRAIN; 3 more responses consumed; no line_ready; IDLE; next miss at 0x8000 fills correctly.
- Line change:
  - Stimulus: miss_addr changes 0x1234->0x1238 during FILL, then later ->0x2000.
  - Required: first change is ignored; second causes an abort and drain.
- Reset mid-fill:
  - Stimulus: rst_n low asynchronously during FILL.
  - Required: bus_req_valid and line_ready go 0 immediately; state IDLE; line_data=0.
